rf_wb_arbiter: RTL and testbench

Shares the register file's single write port (we3/wa3/wd3) among NREQ writeback requesters, such as ALU, load unit and mul/div, using round-robin arbitration. Tracks in-flight destination registers in a 32-entry busy scoreboard so the control FSM can stall on hazards. Provides a flush/drain sequence and sits between the multicycle control unit and regfile.

---
 rtl/rf_wb_pkg.sv | 18 +
 rtl/rf_wb_arbiter_rr.sv | 47 ++++
 rtl/rf_wb_arbiter.sv | 142 ++++++++++++++
 tb/tb_rf_wb_arbiter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/rf_wb_pkg.sv
// Shared types for the register-file writeback arbiter: FSM states,
// register count and address/data typedefs.
package rf_wb_pkg;

  localparam int NREG   = 32;
  localparam int AW_W   = 5;
  localparam int XLEN_W = 32;

  typedef logic [AW_W-1:0]   rf_addr_t;
  typedef logic [XLEN_W-1:0] rf_data_t;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    DRAIN   = 2'd1,
    DRAINED = 2'd2
  } wb_state_e;

endpackage

// File: rtl/rf_wb_arbiter_rr.sv
// rr_arbiter: N-way round-robin arbiter. One-hot grant to the first request
// at or after the pointer; the pointer moves past the winner on each grant.
module rr_arbiter #(
  parameter  int N  = 3,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt,
  output logic         gnt_any
);

  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] gnt_idx;

  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N) s = s - N;
    return PW'(s);
  endfunction

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!gnt_any && req[wrap_add(ptr_q, k)]) begin
        gnt_any = 1'b1;
        gnt_idx = wrap_add(ptr_q, k);
      end
    end
    if (gnt_any) begin
      gnt   = {{(N-1){1'b0}}, 1'b1} << gnt_idx;
      ptr_d = wrap_add(gnt_idx, 1);
    end else begin
      ptr_d = ptr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Round-robin sharing of the regfile write port with a busy scoreboard and
// flush/drain FSM. Define RF_WB_FWD_EN to add the same-cycle forwarding port.
module rf_wb_arbiter
  import rf_wb_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      wb_valid,
  output logic [NREQ-1:0]      wb_ready,
  input  logic [NREQ*AW-1:0]   wb_wa,
  input  logic [NREQ*XLEN-1:0] wb_wd,
  input  logic                 iss_valid,
  input  logic [AW-1:0]        iss_rd,
  input  logic                 flush,
  output logic                 we3,
  output logic [AW-1:0]        wa3,
  output logic [XLEN-1:0]      wd3,
  output logic [NREG-1:0]      busy,
  output logic                 drained,
  output logic                 sb_err
`ifdef RF_WB_FWD_EN
  ,
  input  logic [AW-1:0]        fwd_ra,
  output logic                 fwd_hit,
  output logic [XLEN-1:0]      fwd_data
`endif
);

  wb_state_e         state_q, state_d;
  logic [NREG-1:0]   busy_q, busy_d;
  logic              sb_err_q, sb_err_d;
  logic              drained_q, drained_d;
  logic              we3_q, we3_d;
  logic [AW-1:0]     wa3_q, wa3_d;
  logic [XLEN-1:0]   wd3_q, wd3_d;

  logic [NREQ-1:0]   gnt_s;
  logic              gnt_any_s;
  logic [AW-1:0]     sel_wa_s;
  logic [XLEN-1:0]   sel_wd_s;
  logic              wr_en_s;
  logic              iss_take_s;
  logic              set_en_s;

  rr_arbiter #(.N(NREQ)) u_rr (
    .clk     (clk),
    .reset   (reset),
    .req     (wb_valid),
    .gnt     (gnt_s),
    .gnt_any (gnt_any_s)
  );

  assign wb_ready = gnt_s;

  always_comb begin
    sel_wa_s = '0;
    sel_wd_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_s[i]) begin
        sel_wa_s = wb_wa[i*AW +: AW];
        sel_wd_s = wb_wd[i*XLEN +: XLEN];
      end
    end
  end

  // x0 writes complete the handshake but never reach the regfile.
  assign wr_en_s    = gnt_any_s && (sel_wa_s != '0);
  assign iss_take_s = iss_valid && ((state_q == RUN) || ((state_q == DRAINED) && !flush));
  assign set_en_s   = iss_take_s && (iss_rd != '0);

  always_comb begin
    busy_d = busy_q;
    if (wr_en_s) busy_d[sel_wa_s] = 1'b0;
    if (set_en_s) busy_d[iss_rd] = 1'b1;
    busy_d[0] = 1'b0;

    sb_err_d = sb_err_q
             | (set_en_s && busy_q[iss_rd] && !(wr_en_s && (sel_wa_s == iss_rd)))
             | (wr_en_s && !busy_q[sel_wa_s]);

    we3_d = wr_en_s;
    wa3_d = wr_en_s ? sel_wa_s : wa3_q;
    wd3_d = wr_en_s ? sel_wd_s : wd3_q;

    case (state_q)
      RUN: begin
        state_d = flush ? DRAIN : RUN;
      end
      DRAIN: begin
        if (flush)                                    state_d = DRAIN;
        else if ((busy_q == '0) && (wb_valid == '0))  state_d = DRAINED;
        else                                          state_d = DRAIN;
      end
      DRAINED: begin
        if (flush)          state_d = DRAIN;
        else if (iss_valid) state_d = RUN;
        else                state_d = DRAINED;
      end
      default: state_d = RUN;
    endcase
    drained_d = (state_d == DRAINED);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= RUN;
      busy_q    <= '0;
      sb_err_q  <= 1'b0;
      drained_q <= 1'b0;
      we3_q     <= 1'b0;
      wa3_q     <= '0;
      wd3_q     <= '0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      sb_err_q  <= sb_err_d;
      drained_q <= drained_d;
      we3_q     <= we3_d;
      wa3_q     <= wa3_d;
      wd3_q     <= wd3_d;
    end
  end

  assign we3     = we3_q;
  assign wa3     = wa3_q;
  assign wd3     = wd3_q;
  assign busy    = busy_q;
  assign sb_err  = sb_err_q;
  assign drained = drained_q;

`ifdef RF_WB_FWD_EN
  always_comb begin
    fwd_hit  = we3_q && (wa3_q == fwd_ra) && (fwd_ra != '0);
    fwd_data = fwd_hit ? wd3_q : '0;
  end
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed scenarios then random
// traffic, all compared against a behavioural model of the writeback rules.
module tb_rf_wb_arbiter;

  localparam int NREQ = 3;
  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int M_RUN = 0, M_DRAIN = 1, M_DRAINED = 2;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NREQ-1:0]      wb_valid, wb_ready;
  logic [NREQ*AW-1:0]   wb_wa;
  logic [NREQ*XLEN-1:0] wb_wd;
  logic                 iss_valid;
  logic [AW-1:0]        iss_rd;
  logic                 flush;
  logic                 we3;
  logic [AW-1:0]        wa3;
  logic [XLEN-1:0]      wd3;
  logic [31:0]          busy;
  logic                 drained, sb_err;
`ifdef RF_WB_FWD_EN
  logic [AW-1:0]        fwd_ra;
  logic                 fwd_hit;
  logic [XLEN-1:0]      fwd_data;
`endif

  rf_wb_arbiter #(.NREQ(NREQ), .XLEN(XLEN), .AW(AW)) dut (
    .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_wa(wb_wa), .wb_wd(wb_wd), .iss_valid(iss_valid), .iss_rd(iss_rd),
    .flush(flush), .we3(we3), .wa3(wa3), .wd3(wd3), .busy(busy),
    .drained(drained), .sb_err(sb_err)
`ifdef RF_WB_FWD_EN
    , .fwd_ra(fwd_ra), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model state
  int          m_ptr;
  bit          m_busy[32];
  bit          m_err;
  int          m_state;
  bit          m_we;
  logic [4:0]  m_wa;
  logic [31:0] m_wd;
  logic [AW-1:0]   r_wa[NREQ];
  logic [XLEN-1:0] r_wd[NREQ];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_busy();
    logic [31:0] v;
    for (int r = 0; r < 32; r++) v[r] = m_busy[r];
    return v;
  endfunction

  task automatic idle();
    reset = 1'b0; wb_valid = '0; iss_valid = 1'b0; iss_rd = '0; flush = 1'b0;
  endtask

  // One clock: inputs already set at the falling edge.
  task automatic cycle();
    int g;
    int nstate;
    logic [4:0] wa;
    bit wr, take;
    for (int i = 0; i < NREQ; i++) begin
      wb_wa[i*AW +: AW]     = r_wa[i];
      wb_wd[i*XLEN +: XLEN] = r_wd[i];
    end
    #1;
    g = -1;
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = (m_ptr + k) % NREQ;
      if (g < 0 && wb_valid[j]) g = j;
    end
    check_eq("wb_ready", wb_ready, (g < 0) ? 0 : (1 << g));

    if (reset) begin
      m_ptr = 0; m_err = 0; m_state = M_RUN; m_we = 0; m_wa = '0; m_wd = '0;
      for (int r = 0; r < 32; r++) m_busy[r] = 0;
    end else begin
      wa   = (g >= 0) ? r_wa[g] : 5'd0;
      wr   = (g >= 0) && (wa != 5'd0);
      take = iss_valid && (m_state == M_RUN || (m_state == M_DRAINED && !flush));
      if (take && iss_rd != 0 && m_busy[iss_rd] && !(wr && wa == iss_rd)) m_err = 1;
      if (wr && !m_busy[wa]) m_err = 1;
      nstate = m_state;
      if (flush) nstate = M_DRAIN;
      else if (m_state == M_DRAIN && model_busy() == 32'd0 && wb_valid == '0) nstate = M_DRAINED;
      else if (m_state == M_DRAINED && iss_valid) nstate = M_RUN;
      if (wr) m_busy[wa] = 0;
      if (take && iss_rd != 0) m_busy[iss_rd] = 1;
      m_we = wr;
      if (wr) begin m_wa = wa; m_wd = r_wd[g]; end
      if (g >= 0) m_ptr = (g + 1) % NREQ;
      m_state = nstate;
    end

    @(posedge clk); #1;
    check_eq("we3", we3, m_we);
    check_eq("wa3", wa3, m_wa);
    check_eq("wd3", wd3, m_wd);
    check_eq("busy", busy, model_busy());
    check_eq("sb_err", sb_err, m_err);
    check_eq("drained", drained, m_state == M_DRAINED);
`ifdef RF_WB_FWD_EN
    fwd_ra = ($urandom_range(0, 1) == 1) ? m_wa : AW'($urandom_range(0, 31));
    #1;
    check_eq("fwd_hit", fwd_hit, m_we && fwd_ra == m_wa && fwd_ra != 0);
    check_eq("fwd_data", fwd_data, (m_we && fwd_ra == m_wa && fwd_ra != 0) ? m_wd : 32'd0);
`endif
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle(); reset = 1'b1; cycle(); idle();
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) begin r_wa[i] = '0; r_wd[i] = '0; end
    m_ptr = 0; m_err = 0; m_state = M_RUN; m_we = 0; m_wa = '0; m_wd = '0;
    for (int r = 0; r < 32; r++) m_busy[r] = 0;
`ifdef RF_WB_FWD_EN
    fwd_ra = '0;
`endif
    idle(); reset = 1'b1;
    @(negedge clk);
    cycle(); cycle();
    check_eq("rst_we3", we3, 1'b0);
    check_eq("rst_busy", busy, 32'd0);
    check_eq("rst_drained", drained, 1'b0);
    idle();

    // requesters 0 and 2 alternate
    wb_valid = 3'b101;
    r_wa[0] = 5'd5; r_wd[0] = 32'd7; r_wa[2] = 5'd9; r_wd[2] = 32'd11;
    for (int n = 0; n < 4; n++) begin
      cycle();
      check_eq("alt_wa3", wa3, (n % 2 == 0) ? 5 : 9);
      check_eq("alt_wd3", wd3, (n % 2 == 0) ? 7 : 11);
    end
    do_reset();

    // issue then matching writeback
    iss_valid = 1'b1; iss_rd = 5'd5; cycle(); idle();
    check_eq("iss_busy5", busy[5], 1'b1);
    wb_valid = 3'b010; r_wa[1] = 5'd5; r_wd[1] = 32'h1234; cycle(); idle();
    check_eq("wb_busy5", busy[5], 1'b0);
    check_eq("wb_wa3", wa3, 5'd5);
    cycle();
    check_eq("wb_sb_err", sb_err, 1'b0);

    // x0 writeback is swallowed
    wb_valid = 3'b001; r_wa[0] = 5'd0; r_wd[0] = 32'hDEAD; cycle(); idle();
    check_eq("x0_we3", we3, 1'b0);
    check_eq("x0_busy", busy, 32'd0);

    // double issue, then stray writeback
    iss_valid = 1'b1; iss_rd = 5'd9; cycle(); cycle(); idle();
    check_eq("dbl_err", sb_err, 1'b1);
    cycle(); cycle();
    check_eq("err_sticky", sb_err, 1'b1);
    do_reset();
    check_eq("err_cleared", sb_err, 1'b0);
    wb_valid = 3'b001; r_wa[0] = 5'd3; r_wd[0] = 32'h3; cycle(); idle();
    check_eq("stray_err", sb_err, 1'b1);
    do_reset();

    // flush / drain sequence
    iss_valid = 1'b1; iss_rd = 5'd5; cycle(); idle();
    flush = 1'b1; cycle(); idle();
    iss_valid = 1'b1; iss_rd = 5'd6; cycle(); idle();
    check_eq("drain_ign6", busy[6], 1'b0);
    wb_valid = 3'b010; r_wa[1] = 5'd5; r_wd[1] = 32'h77; cycle(); idle();
    check_eq("drain_not_yet", drained, 1'b0);
    cycle();
    check_eq("drained", drained, 1'b1);
    iss_valid = 1'b1; iss_rd = 5'd6; cycle(); idle();
    check_eq("resume_busy6", busy[6], 1'b1);
    check_eq("resume_run", drained, 1'b0);
    check_eq("drain_err", sb_err, 1'b0);

`ifdef RF_WB_FWD_EN
    do_reset();
    wb_valid = 3'b001; r_wa[0] = 5'd3; r_wd[0] = 32'h55; cycle(); idle();
    fwd_ra = 5'd3; #1;
    check_eq("fwd_hit3", fwd_hit, 1'b1);
    check_eq("fwd_data3", fwd_data, 32'h55);
    fwd_ra = 5'd4; #1;
    check_eq("fwd_miss4", fwd_hit, 1'b0);
    @(negedge clk);
`endif

    // random traffic with occasional flush and mid-run reset
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      wb_valid  = NREQ'($urandom_range(0, (1 << NREQ) - 1));
      for (int i = 0; i < NREQ; i++) begin
        r_wa[i] = AW'($urandom_range(0, 7));
        r_wd[i] = $urandom;
      end
      iss_valid = ($urandom_range(0, 3) == 0);
      iss_rd    = AW'($urandom_range(0, 7));
      flush     = ($urandom_range(0, 19) == 0);
      reset     = ($urandom_range(0, 99) == 0);
      cycle();
    end
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
